// File: rtl/multicycle_control.sv
`default_nettype none
// ============================================================================
// Module  : multicycle_control
// Brief   : Fetch/decode/execute/memory sequencer for the multicycle CPU.
// Revision: 1.0
// ============================================================================
module multicycle_control #(
  parameter int WIDTH_OPCODE = 4,
  parameter int ALU_OP_WIDTH = 2,
  parameter int COUNT_WIDTH  = 16
) (
  input  logic                    clock,
  input  logic                    resetn,
  input  logic                    run,
  input  logic [WIDTH_OPCODE-1:0] opcode,
  input  logic                    alu_zero,
  input  logic                    mem_ready,
  output logic                    mem_req,
  output logic                    mem_we,
  output logic                    addr_sel,
  output logic                    ir_load,
  output logic                    pc_inc,
  output logic                    pc_load,
  output logic                    reg_write,
  output logic [1:0]              wb_sel,
  output logic [ALU_OP_WIDTH-1:0] alu_op,
  output logic                    halted,
  output logic                    illegal,
  output logic [COUNT_WIDTH-1:0]  instr_count
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_HALT   = 3'd5
  } state_t;

  localparam logic [WIDTH_OPCODE-1:0] c_OP_NOP  = WIDTH_OPCODE'(0);
  localparam logic [WIDTH_OPCODE-1:0] c_OP_MV   = WIDTH_OPCODE'(1);
  localparam logic [WIDTH_OPCODE-1:0] c_OP_MVI  = WIDTH_OPCODE'(2);
  localparam logic [WIDTH_OPCODE-1:0] c_OP_ADD  = WIDTH_OPCODE'(3);
  localparam logic [WIDTH_OPCODE-1:0] c_OP_SUB  = WIDTH_OPCODE'(4);
  localparam logic [WIDTH_OPCODE-1:0] c_OP_AND  = WIDTH_OPCODE'(5);
  localparam logic [WIDTH_OPCODE-1:0] c_OP_LD   = WIDTH_OPCODE'(6);
  localparam logic [WIDTH_OPCODE-1:0] c_OP_ST   = WIDTH_OPCODE'(7);
  localparam logic [WIDTH_OPCODE-1:0] c_OP_JMP  = WIDTH_OPCODE'(8);
  localparam logic [WIDTH_OPCODE-1:0] c_OP_BZ   = WIDTH_OPCODE'(9);
  localparam logic [WIDTH_OPCODE-1:0] c_OP_HALT = WIDTH_OPCODE'(15);

  state_t                 r_state;
  logic [COUNT_WIDTH-1:0] r_count;

  logic w_is_nop;
  logic w_is_ldst;
  logic w_is_halt;
  logic w_is_illegal;
  logic w_retire;

  always_comb begin
    w_is_nop     = 1'b0;
    w_is_ldst    = 1'b0;
    w_is_halt    = 1'b0;
    w_is_illegal = 1'b0;
    case (opcode)
      c_OP_NOP:                  w_is_nop  = 1'b1;
      c_OP_LD, c_OP_ST:          w_is_ldst = 1'b1;
      c_OP_HALT:                 w_is_halt = 1'b1;
      c_OP_MV, c_OP_MVI, c_OP_ADD, c_OP_SUB,
      c_OP_AND, c_OP_JMP, c_OP_BZ: ;
      default:                   w_is_illegal = 1'b1;
    endcase
  end

  // HALT retires on entry; NOP/illegal retire straight out of DECODE.
  assign w_retire = ((r_state == S_DECODE) && (w_is_nop || w_is_illegal || w_is_halt)) ||
                    (r_state == S_EXEC) ||
                    ((r_state == S_MEM) && mem_ready);

  always_ff @(posedge clock) begin
    if (!resetn) begin
      r_state <= S_IDLE;
      r_count <= '0;
    end else begin
      if (w_retire) r_count <= r_count + COUNT_WIDTH'(1);
      case (r_state)
        S_IDLE:   if (run) r_state <= S_FETCH;
        S_FETCH:  if (mem_ready) r_state <= S_DECODE;
        S_DECODE: begin
          if (w_is_halt)      r_state <= S_HALT;
          else if (w_is_ldst) r_state <= S_MEM;
          else if (w_is_nop || w_is_illegal) r_state <= S_FETCH;
          else                r_state <= S_EXEC;
        end
        S_EXEC:   r_state <= S_FETCH;
        S_MEM:    if (mem_ready) r_state <= S_FETCH;
        S_HALT:   if (!run) r_state <= S_IDLE;
        default:  r_state <= S_IDLE;
      endcase
    end
  end

  assign instr_count = r_count;

  always_comb begin
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    addr_sel  = 1'b0;
    ir_load   = 1'b0;
    pc_inc    = 1'b0;
    pc_load   = 1'b0;
    reg_write = 1'b0;
    wb_sel    = 2'd0;
    alu_op    = '0;
    halted    = 1'b0;
    illegal   = 1'b0;
    case (r_state)
      S_FETCH: begin
        mem_req = 1'b1;
        if (mem_ready) begin
          ir_load = 1'b1;
          pc_inc  = 1'b1;
        end
      end
      S_DECODE: illegal = w_is_illegal;
      S_EXEC: begin
        case (opcode)
          c_OP_MV:  begin reg_write = 1'b1; wb_sel = 2'd1; end
          c_OP_MVI: begin reg_write = 1'b1; wb_sel = 2'd2; end
          c_OP_ADD: begin reg_write = 1'b1; alu_op = ALU_OP_WIDTH'(0); end
          c_OP_SUB: begin reg_write = 1'b1; alu_op = ALU_OP_WIDTH'(1); end
          c_OP_AND: begin reg_write = 1'b1; alu_op = ALU_OP_WIDTH'(2); end
          c_OP_JMP: pc_load = 1'b1;
          c_OP_BZ:  pc_load = alu_zero;
          default: ;
        endcase
      end
      S_MEM: begin
        // Address/direction stay constant for the whole wait so memory sees a stable request.
        mem_req  = 1'b1;
        addr_sel = 1'b1;
        mem_we   = (opcode == c_OP_ST);
        if (mem_ready && (opcode == c_OP_LD)) begin
          reg_write = 1'b1;
          wb_sel    = 2'd3;
        end
      end
      S_HALT: halted = 1'b1;
      default: ;
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_multicycle_control.sv
`default_nettype none
// ============================================================================
// Module  : tb_multicycle_control
// Brief   : Scoreboard bench for multicycle_control (16-bit and 4-bit counters).
// Revision: 1.0
// ============================================================================
module tb_multicycle_control;

  // Output vector: {mem_req, mem_we, addr_sel, ir_load, pc_inc, pc_load,
  //                 reg_write, wb_sel[1:0], alu_op[1:0], halted, illegal}
  localparam logic [12:0] O_ZERO  = 13'h0000;
  localparam logic [12:0] O_FWAIT = 13'h1000;
  localparam logic [12:0] O_FRDY  = 13'h1300;
  localparam logic [12:0] O_MV    = 13'h0050;
  localparam logic [12:0] O_MVI   = 13'h0060;
  localparam logic [12:0] O_ADD   = 13'h0040;
  localparam logic [12:0] O_SUB   = 13'h0044;
  localparam logic [12:0] O_AND   = 13'h0048;
  localparam logic [12:0] O_JMP   = 13'h0080;
  localparam logic [12:0] O_LDW   = 13'h1400;
  localparam logic [12:0] O_LDR   = 13'h1470;
  localparam logic [12:0] O_STW   = 13'h1C00;
  localparam logic [12:0] O_HALT  = 13'h0002;
  localparam logic [12:0] O_ILL   = 13'h0001;

  logic       clk = 1'b0;
  logic       resetn = 1'b0;
  logic       run = 1'b0;
  logic [3:0] opcode = 4'd0;
  logic       alu_zero = 1'b0;
  logic       mem_ready = 1'b0;

  logic        mem_req, mem_we, addr_sel, ir_load, pc_inc, pc_load, reg_write, halted, illegal;
  logic [1:0]  wb_sel, alu_op;
  logic [15:0] instr_count;

  logic        d4_mem_req, d4_mem_we, d4_addr_sel, d4_ir_load, d4_pc_inc, d4_pc_load;
  logic        d4_reg_write, d4_halted, d4_illegal;
  logic [1:0]  d4_wb_sel, d4_alu_op;
  logic [3:0]  cnt4;

  logic [12:0] outs;
  assign outs = {mem_req, mem_we, addr_sel, ir_load, pc_inc, pc_load, reg_write,
                 wb_sel, alu_op, halted, illegal};

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [15:0] exp_cnt  = 16'd0;
  logic [32:0] exp_q[$];
  logic [32:0] obs_q[$];

  always #5 clk = ~clk;

  multicycle_control #(.WIDTH_OPCODE(4), .ALU_OP_WIDTH(2), .COUNT_WIDTH(16)) dut (
    .clock(clk), .resetn(resetn), .run(run), .opcode(opcode), .alu_zero(alu_zero),
    .mem_ready(mem_ready), .mem_req(mem_req), .mem_we(mem_we), .addr_sel(addr_sel),
    .ir_load(ir_load), .pc_inc(pc_inc), .pc_load(pc_load), .reg_write(reg_write),
    .wb_sel(wb_sel), .alu_op(alu_op), .halted(halted), .illegal(illegal),
    .instr_count(instr_count)
  );

  multicycle_control #(.WIDTH_OPCODE(4), .ALU_OP_WIDTH(2), .COUNT_WIDTH(4)) dut4 (
    .clock(clk), .resetn(resetn), .run(run), .opcode(opcode), .alu_zero(alu_zero),
    .mem_ready(mem_ready), .mem_req(d4_mem_req), .mem_we(d4_mem_we), .addr_sel(d4_addr_sel),
    .ir_load(d4_ir_load), .pc_inc(d4_pc_inc), .pc_load(d4_pc_load), .reg_write(d4_reg_write),
    .wb_sel(d4_wb_sel), .alu_op(d4_alu_op), .halted(d4_halted), .illegal(d4_illegal),
    .instr_count(cnt4)
  );

  // One clock cycle: drive inputs, push expectation, capture what the DUT shows.
  task automatic cyc(input logic r, input logic [3:0] op, input logic z,
                     input logic rdy, input logic [12:0] e);
    run = r; opcode = op; alu_zero = z; mem_ready = rdy;
    exp_q.push_back({e, exp_cnt, exp_cnt[3:0]});
    #2;
    obs_q.push_back({outs, instr_count, cnt4});
    @(negedge clk);
  endtask

  task automatic test_reset();
    logic [32:0] e, o;
    int k = 0;
    cyc(1, 4'd6, 0, 1, O_ZERO);
    cyc(1, 4'd6, 0, 1, O_FRDY);
    cyc(1, 4'd6, 0, 1, O_ZERO);
    cyc(1, 4'd6, 0, 0, O_LDW);
    resetn = 1'b0;
    cyc(1, 4'd6, 0, 0, O_LDW);
    exp_cnt = 16'd0;
    cyc(1, 4'd6, 0, 0, O_ZERO);
    resetn = 1'b1;
    cyc(0, 4'd6, 0, 1, O_ZERO);
    cyc(0, 4'd6, 0, 1, O_ZERO);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); n_checks++;
      if (o !== e) begin
        n_fail++;
        $display("FAIL reset[%0d] got outs/cnt/cnt4=%h expected %h", k, o, e);
      end
      k++;
    end
  endtask

  task automatic test_add();
    logic [32:0] e, o;
    int k = 0;
    cyc(1, 4'd3, 0, 1, O_ZERO);
    cyc(1, 4'd3, 0, 1, O_FRDY);
    cyc(1, 4'd3, 0, 1, O_ZERO);
    cyc(1, 4'd3, 0, 1, O_ADD);
    exp_cnt++;
    cyc(1, 4'd3, 0, 0, O_FWAIT);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); n_checks++;
      if (o !== e) begin
        n_fail++;
        $display("FAIL add[%0d] got outs/cnt/cnt4=%h expected %h", k, o, e);
      end
      k++;
    end
  endtask

  task automatic test_alu_ops();
    logic [32:0] e, o;
    logic [3:0]  ops[6];
    logic [12:0] eo[6];
    int k = 0;
    ops = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd8};
    eo  = '{O_MV, O_MVI, O_ADD, O_SUB, O_AND, O_JMP};
    for (int i = 0; i < 6; i++) begin
      cyc(1, ops[i], 0, 1, O_FRDY);
      cyc(1, ops[i], 0, 1, O_ZERO);
      cyc(1, ops[i], 0, 1, eo[i]);
      exp_cnt++;
    end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); n_checks++;
      if (o !== e) begin
        n_fail++;
        $display("FAIL alu_ops[%0d] got outs/cnt/cnt4=%h expected %h", k, o, e);
      end
      k++;
    end
  endtask

  task automatic test_load_store();
    logic [32:0] e, o;
    int k = 0;
    cyc(0, 4'd6, 0, 0, O_FWAIT);
    cyc(1, 4'd6, 0, 1, O_FRDY);
    cyc(0, 4'd6, 0, 1, O_ZERO);
    cyc(0, 4'd6, 0, 0, O_LDW);
    cyc(1, 4'd6, 0, 0, O_LDW);
    cyc(1, 4'd6, 0, 0, O_LDW);
    cyc(1, 4'd6, 0, 1, O_LDR);
    exp_cnt++;
    cyc(1, 4'd7, 0, 1, O_FRDY);
    cyc(1, 4'd7, 0, 1, O_ZERO);
    cyc(1, 4'd7, 0, 0, O_STW);
    cyc(1, 4'd7, 0, 1, O_STW);
    exp_cnt++;
    cyc(1, 4'd7, 0, 0, O_FWAIT);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); n_checks++;
      if (o !== e) begin
        n_fail++;
        $display("FAIL load_store[%0d] got outs/cnt/cnt4=%h expected %h", k, o, e);
      end
      k++;
    end
  endtask

  task automatic test_branch();
    logic [32:0] e, o;
    int k = 0;
    cyc(1, 4'd9, 1, 1, O_FRDY);
    cyc(1, 4'd9, 1, 1, O_ZERO);
    cyc(1, 4'd9, 1, 1, O_JMP);
    exp_cnt++;
    cyc(1, 4'd9, 0, 1, O_FRDY);
    cyc(1, 4'd9, 0, 1, O_ZERO);
    cyc(1, 4'd9, 0, 1, O_ZERO);
    exp_cnt++;
    cyc(1, 4'd9, 0, 0, O_FWAIT);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); n_checks++;
      if (o !== e) begin
        n_fail++;
        $display("FAIL branch[%0d] got outs/cnt/cnt4=%h expected %h", k, o, e);
      end
      k++;
    end
  endtask

  task automatic test_illegal();
    logic [32:0] e, o;
    int k = 0;
    cyc(1, 4'd12, 0, 1, O_FRDY);
    cyc(1, 4'd12, 0, 1, O_ILL);
    exp_cnt++;
    cyc(1, 4'd0, 0, 1, O_FRDY);
    cyc(1, 4'd0, 0, 1, O_ZERO);
    exp_cnt++;
    cyc(1, 4'd0, 0, 0, O_FWAIT);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); n_checks++;
      if (o !== e) begin
        n_fail++;
        $display("FAIL illegal[%0d] got outs/cnt/cnt4=%h expected %h", k, o, e);
      end
      k++;
    end
  endtask

  task automatic test_halt();
    logic [32:0] e, o;
    int k = 0;
    cyc(1, 4'd15, 0, 1, O_FRDY);
    cyc(1, 4'd15, 0, 1, O_ZERO);
    exp_cnt++;
    for (int i = 0; i < 10; i++) cyc(1, 4'd15, 0, 1, O_HALT);
    cyc(0, 4'd15, 0, 1, O_HALT);
    cyc(0, 4'd15, 0, 1, O_ZERO);
    cyc(0, 4'd15, 0, 1, O_ZERO);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); n_checks++;
      if (o !== e) begin
        n_fail++;
        $display("FAIL halt[%0d] got outs/cnt/cnt4=%h expected %h", k, o, e);
      end
      k++;
    end
  endtask

  task automatic test_wrap();
    logic [32:0] e, o;
    int k = 0;
    resetn = 1'b0;
    cyc(0, 4'd0, 0, 1, O_ZERO);
    exp_cnt = 16'd0;
    resetn = 1'b1;
    cyc(1, 4'd0, 0, 1, O_ZERO);
    for (int i = 0; i < 16; i++) begin
      cyc(1, 4'd0, 0, 1, O_FRDY);
      cyc(1, 4'd0, 0, 1, O_ZERO);
      exp_cnt++;
    end
    cyc(1, 4'd0, 0, 1, O_FRDY);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); n_checks++;
      if (o !== e) begin
        n_fail++;
        $display("FAIL wrap[%0d] got outs/cnt/cnt4=%h expected %h", k, o, e);
      end
      k++;
    end
  endtask

  initial begin
    resetn = 1'b0;
    run    = 1'b0;
    @(negedge clk);
    @(negedge clk);
    resetn = 1'b1;
    test_reset();
    test_add();
    test_alu_ops();
    test_load_store();
    test_branch();
    test_illegal();
    test_halt();
    test_wrap();
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
